// File: rtl/mem_responder_if.sv
// Word-memory request/response bus between an initiator (processor) and a responder.
// The initiator holds mem_read/mem_write until it sees the one-cycle mem_ready pulse.
interface mem_responder_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_WIDTH-1:0] mem_wdata;
  logic [WORD_WIDTH-1:0] mem_rdata;
  logic                  mem_ready;
  logic                  mem_err;

  modport master (
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready, mem_err
  );

  modport slave (
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-array memory responder: accepts one access at a time, inserts WAIT_CYCLES wait
// states, then answers with a one-cycle mem_ready (and mem_err for rejected accesses).
module mem_responder #(
  parameter int WORD_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);

  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                  state_q,    state_d;
  logic [CNT_W-1:0]        cnt_q,      cnt_d;
  logic [DEPTH_LOG2-1:0]   idx_q,      idx_d;
  logic [WORD_WIDTH-1:0]   wdata_q,    wdata_d;
  logic                    is_write_q, is_write_d;
  logic                    rej_q,      rej_d;
  logic [WORD_WIDTH-1:0]   rdata_q,    rdata_d;
  logic                    ready_q,    ready_d;
  logic                    err_q,      err_d;
  logic                    go_resp;
  logic                    req;
  logic                    misaligned;
  logic                    out_of_range;

  logic [WORD_WIDTH-1:0]   mem [2**DEPTH_LOG2];

  assign req          = bus.mem_read | bus.mem_write;
  assign misaligned   = |bus.mem_addr[1:0];
  assign out_of_range = |bus.mem_addr[ADDR_WIDTH-1:DEPTH_LOG2+2];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    rej_d      = rej_q;
    rdata_d    = rdata_q;
    ready_d    = 1'b0;
    err_d      = 1'b0;
    go_resp    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d      = bus.mem_addr[DEPTH_LOG2+1:2];
          wdata_d    = bus.mem_wdata;
          is_write_d = bus.mem_write;
          rej_d      = misaligned | out_of_range | (bus.mem_read & bus.mem_write);
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            go_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A withdrawn request wins over an expiring counter: the access is simply dropped.
        if (!req) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Response outputs are registered on the edge that enters RESP, so they are
    // valid for exactly the RESP cycle; a write response leaves mem_rdata alone.
    if (go_resp) begin
      state_d = ST_RESP;
      ready_d = 1'b1;
      err_d   = rej_d;
      if (rej_d) begin
        rdata_d = '0;
      end else if (!is_write_d) begin
        rdata_d = mem[idx_d];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      rej_q      <= 1'b0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      rej_q      <= rej_d;
      rdata_q    <= rdata_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  // NOTE: the array has no reset; contents survive rst and it maps onto plain RAM.
  // The commit happens on the edge ending RESP and is suppressed if rst lands on that edge.
  always_ff @(posedge clk) begin
    if (!rst && state_q == ST_RESP && is_write_q && !rej_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;

endmodule
